mem_1w1r_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO built around a 1-write/1-read memory array with registered read port.
- Adds pointer management, full/empty and programmable almost-full/almost-empty flags, occupancy count, sticky overflow/underflow error flags, and synchronous flush.
- Used as the generic data buffer between the AHB slave front-end and the XSPI controller datapath in the same clock domain.

---
 rtl/mem_1w1r_sync_fifo.sv | 145 ++++++++++++++
 tb/tb_mem_1w1r_sync_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_1w1r_sync_fifo.sv
// Single-clock FIFO around a 1-write/1-read memory with a registered read port.
// Define MEM_1W1R_FIFO_FWFT_EN for first-word fall-through (output register holds the head).
module mem_1w1r_sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PTR_WIDTH     = 3,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  afull,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  aempty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** PTR_WIDTH;
  localparam int unsigned CNT_W = PTR_WIDTH + 1;
`ifdef MEM_1W1R_FIFO_FWFT_EN
  localparam int unsigned FULL_CNT = DEPTH + 1;
`else
  localparam int unsigned FULL_CNT = DEPTH;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;

  logic             wr_acc;
  logic             rd_acc;
  logic             rdv_nxt;
  logic             empty_nxt;
  logic             ovf_set;
  logic             udf_set;
  logic [CNT_W-1:0] count_nxt;

`ifdef MEM_1W1R_FIFO_FWFT_EN
  // rd_valid doubles as the output-register occupancy bit; mem_cnt tracks the array only.
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] mem_cnt_nxt;
  logic             pop;

  always_comb begin
    pop         = rd_en & rd_valid & ~flush;
    wr_acc      = wr_en & ~full & ~flush;
    rd_acc      = (mem_cnt != '0) & (~rd_valid | pop) & ~flush;
    rdv_nxt     = ~flush & (rd_acc | (rd_valid & ~pop));
    mem_cnt_nxt = flush ? '0 : (mem_cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc));
    count_nxt   = mem_cnt_nxt + CNT_W'(rdv_nxt);
    empty_nxt   = ~rdv_nxt;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      mem_cnt <= '0;
    end else begin
      mem_cnt <= mem_cnt_nxt;
    end
  end
`else
  always_comb begin
    wr_acc    = wr_en & ~full & ~flush;
    rd_acc    = rd_en & ~empty & ~flush;
    rdv_nxt   = rd_acc;
    count_nxt = flush ? '0 : (count + CNT_W'(wr_acc) - CNT_W'(rd_acc));
    empty_nxt = (count_nxt == '0);
  end
`endif

  // Errors look at the registered flags; a flushing cycle never raises them.
  always_comb begin
    ovf_set = wr_en & full & ~flush;
    udf_set = rd_en & empty & ~flush;
  end

  always_ff @(posedge hclk) begin
    if (wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_data <= mem[rptr];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_WIDTH'(1);
      if (rd_acc) rptr <= rptr + PTR_WIDTH'(1);
    end
  end

  // Flags are computed from the next count so they move with count.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      count    <= '0;
      full     <= 1'b0;
      afull    <= 1'b0;
      empty    <= 1'b1;
      aempty   <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(FULL_CNT));
      afull    <= (count_nxt >= CNT_W'(AFULL_THRESH));
      empty    <= empty_nxt;
      aempty   <= (count_nxt <= CNT_W'(AEMPTY_THRESH));
      rd_valid <= rdv_nxt;
    end
  end

  // Sticky errors: a new set beats a simultaneous clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_1w1r_sync_fifo.sv
// Randomised scoreboard bench for mem_1w1r_sync_fifo in its default (1-cycle read latency) build.
module tb_mem_1w1r_sync_fifo;

  localparam int unsigned DW     = 32;
  localparam int unsigned PW     = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AF_TH  = 6;
  localparam int unsigned AE_TH  = 1;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          flush, clr_err, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          full, afull, empty, aempty, rd_valid, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [PW:0]   count;

  mem_1w1r_sync_fifo #(
    .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_THRESH(AF_TH), .AEMPTY_THRESH(AE_TH)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .afull(afull),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .aempty(aempty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 hclk = ~hclk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents as a queue, plus expected read outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic          ovf_m, udf_m, rdv_m;
  logic [DW-1:0] last_rd;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count",     DW'(count),     DW'(n));
    chk("full",      DW'(full),      DW'(n == DEPTH));
    chk("empty",     DW'(empty),     DW'(n == 0));
    chk("afull",     DW'(afull),     DW'(n >= AF_TH));
    chk("aempty",    DW'(aempty),    DW'(n <= AE_TH));
    chk("overflow",  DW'(overflow),  DW'(ovf_m));
    chk("underflow", DW'(underflow), DW'(udf_m));
    chk("rd_valid",  DW'(rd_valid),  DW'(rdv_m));
    chk("rd_data",   rd_data,        last_rd);
  endtask

  task automatic step(input logic we, input logic re, input logic [DW-1:0] wd,
                      input logic fl, input logic ce);
    logic was_full, was_empty, wa, ra;
    wr_en = we; rd_en = re; wr_data = wd; flush = fl; clr_err = ce;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wa = we && !was_full && !fl;
    ra = re && !was_empty && !fl;
    if (ra) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wa) mq.push_back(wd);
    if (fl) mq.delete();
    if (we && was_full && !fl)       ovf_m = 1'b1;
    else if (ce)                     ovf_m = 1'b0;
    if (re && was_empty && !fl)      udf_m = 1'b1;
    else if (ce)                     udf_m = 1'b0;
    rdv_m = ra;
    @(posedge hclk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    ovf_m = 1'b0; udf_m = 1'b0; rdv_m = 1'b0; last_rd = '0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    forever begin
      @(negedge hclk);
      if (hresetn && rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", DW'(rd_valid), '0);
        end else begin
          chk("scoreboard_rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic rand_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), $urandom,
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 10));
    end
  endtask

  initial begin
    hresetn = 1'b0;
    flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_reset();
    #12 hresetn = 1'b1;
    @(posedge hclk);
    #1;
    check_state();

    // Fill to full with 0x11..0x88, then one rejected write.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i * 'h11), 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Full-with-read-and-write: write must still be rejected.
    step(1'b1, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h88, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Drain everything, then a rejected read.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Four entries, then 20 cycles of simultaneous read and write across the wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 4; i < 24; i++) step(1'b1, 1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Empty: read plus write together, then clear the error.
    step(1'b1, 1'b1, 32'h0000_00E1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Full FIFO flushed while writing (and while reading).
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0F0F, 1'b0, 1'b0);

    rand_phase(300);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    #1 hresetn = 1'b0;
    model_reset();
    #1 check_state();
    @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk);
    #1 check_state();

    rand_phase(300);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    @(negedge hclk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
